// File: rtl/hyper_eot_classifier.sv
// Per-channel EOT classifier: queues rx/tx arm directions and tags each controller EOT as read or write.
// Optional error detection (conflict/underflow/overflow, err_clr_i) is enabled by defining HYPER_EOT_ERR_EN.
module hyper_eot_classifier #(
  parameter  int NB_CH = 2,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   sys_clk_i,
  input  logic                   rstn_i,
  input  logic [NB_CH-1:0]       rx_evt_i,
  input  logic [NB_CH-1:0]       tx_evt_i,
  input  logic [NB_CH-1:0]       eot_i,
  input  logic [NB_CH-1:0]       err_clr_i,
  output logic [NB_CH-1:0]       evt_rx_o,
  output logic [NB_CH-1:0]       evt_tx_o,
  output logic [NB_CH-1:0]       evt_rd_eot_o,
  output logic [NB_CH-1:0]       evt_wr_eot_o,
  output logic [NB_CH-1:0]       dir_o,
  output logic [NB_CH*CNT_W-1:0] count_o,
  output logic [NB_CH*3-1:0]     err_o
);

  localparam int PTR_W = $clog2(DEPTH);

`ifndef HYPER_EOT_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr_i;
`endif

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             dir_q, rd_eot_q, wr_eot_q, evt_rx_q, evt_tx_q;
    logic             rx, tx, eot, push, empty, full, pop, bypass, wr_en, cls_dir;

    always_comb begin
      rx      = rx_evt_i[c];
      tx      = tx_evt_i[c];
      eot     = eot_i[c];
      push    = rx ^ tx;
      empty   = (cnt_q == '0);
      full    = (cnt_q == CNT_W'(DEPTH));
      pop     = eot & ~empty;
      // An EOT on an empty queue consumes a same-cycle arm directly instead of storing it.
      bypass  = eot & empty & push;
      wr_en   = push & ~full & ~bypass;
      cls_dir = dir_q;
      if (!empty)     cls_dir = mem_q[rd_ptr_q];
      else if (push)  cls_dir = rx;
      cnt_nxt = cnt_q;
      case ({wr_en, pop})
        2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
        2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
        default: cnt_nxt = cnt_q;
      endcase
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        mem_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        dir_q    <= 1'b0;
        rd_eot_q <= 1'b0;
        wr_eot_q <= 1'b0;
        evt_rx_q <= 1'b0;
        evt_tx_q <= 1'b0;
      end else begin
        evt_rx_q <= rx;
        evt_tx_q <= tx;
        rd_eot_q <= eot & cls_dir;
        wr_eot_q <= eot & ~cls_dir;
        if (eot) dir_q <= cls_dir;
        if (wr_en) begin
          mem_q[wr_ptr_q] <= rx;
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cnt_q <= cnt_nxt;
      end
    end

    assign evt_rx_o[c]               = evt_rx_q;
    assign evt_tx_o[c]               = evt_tx_q;
    assign evt_rd_eot_o[c]           = rd_eot_q;
    assign evt_wr_eot_o[c]           = wr_eot_q;
    assign dir_o[c]                  = dir_q;
    assign count_o[c*CNT_W +: CNT_W] = cnt_q;

`ifdef HYPER_EOT_ERR_EN
    logic [2:0] err_q;
    logic       conflict, underflow, overflow;

    assign conflict  = rx & tx;
    assign underflow = eot & empty & ~push;
    assign overflow  = push & full;

    // Clear applies first so a same-cycle set survives.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) err_q <= '0;
      else         err_q <= (err_clr_i[c] ? 3'b000 : err_q) | {conflict, underflow, overflow};
    end

    assign err_o[c*3 +: 3] = err_q;
`else
    assign err_o[c*3 +: 3] = '0;
`endif
  end

endmodule

// File: doc/hyper_eot_classifier.md
Name: hyper_eot_classifier

Overview:
- Per-channel end-of-transfer (EOT) classifier that sits between the uDMA linear-channel event lines and the HyperBus controller's EOT output, inside the hyper macro.
- Each rx/tx channel event arms a transfer, and the block queues its direction (read/write) in a per-channel FIFO.
- Each controller EOT pops the queue and is emitted as a registered read-EOT or write-EOT pulse.
- Generalises the single-bit direction tracker to NB_CH channels with queued arms and error detection.

Parameters:
- NB_CH, 2, number of HyperBus channels; each has independent FIFO and logic.
- DEPTH, 4, direction FIFO entries per channel; must be a power of two and ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of each per-channel occupancy count (derived, not overridable).

Ports:
- sys_clk_i  in  1  system clock; all state on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- rx_evt_i  in  NB_CH  rx linear-channel event pulse per channel; arms a read.
- tx_evt_i  in  NB_CH  tx linear-channel event pulse per channel; arms a write.
- eot_i  in  NB_CH  controller end-of-transfer pulse per channel.
- evt_rx_o  out  NB_CH  rx_evt_i registered, 1 cycle delay.
- evt_tx_o  out  NB_CH  tx_evt_i registered, 1 cycle delay.
- evt_rd_eot_o  out  NB_CH  read-EOT pulse.
- evt_wr_eot_o  out  NB_CH  write-EOT pulse.
- dir_o  out  NB_CH  last classified direction per channel; 1 = read.
- count_o  out  NB_CH*CNT_W  FIFO occupancy per channel; channel c is at bits [c*CNT_W +: CNT_W].
- err_o  out  NB_CH*3  sticky flags per channel: {conflict, underflow, overflow}; channel c is at bits [c*3 +: 3].
- err_clr_i  in  NB_CH  clears all error flags of that channel.

Behaviour:
- Reset (async, rstn_i=0):
  - All outputs 0.
  - FIFOs empty, pointers 0, dir_o=0 (write).
- Arm decode, per channel, per cycle:
  - rx&!tx → push 1 (read).
  - tx&!rx → push 0 (write).
  - rx&tx → no push; set conflict flag.
  - neither → no push.
- FIFO:
  - Circular; rd/wr pointers are log2(DEPTH) bits and wrap naturally.
  - count saturates at DEPTH.
- Push when count==DEPTH: the entry is dropped, FIFO is unchanged, overflow flag is set. A simultaneous pop is still honoured.
- EOT with count>0:
  - Pop the head entry; direction = head.
  - Push and pop in the same cycle: head pops, new entry is written at wr_ptr, count is unchanged.
- EOT with count==0:
  - If a valid push arrives the same cycle: bypass. Direction = incoming bit, nothing is stored, count stays 0.
  - Otherwise: direction = current dir_o, underflow flag is set.
- Outputs:
  - evt_rd_eot_o or evt_wr_eot_o pulses for exactly one cycle, on the cycle after eot_i (latency 1).
  - The two outputs are never both high for the same channel.
  - dir_o updates on that same edge.
- Back-to-back eot_i on consecutive cycles gives consecutive pulses, one per EOT, each classified by its own pop.
- Error flags:
  - Sticky until err_clr_i.
  - If clear and set occur in the same cycle, set wins.
- Channels are fully independent; no cross-channel priority.
- count_o and err_o are registered state, with no combinational path from inputs.

Optional Feature:
- HYPER_EOT_ERR_EN defined: conflict/underflow/overflow detection and err_clr_i are active as specified above.
- Not defined:
  - err_o is tied to 0 and err_clr_i is ignored.
  - Overflowing pushes are still dropped silently.
  - Empty-FIFO EOT still falls back to dir_o.
  - The port list is identical in both builds.

Test Plan:
- Reset release, channel 0:
  - rx_evt_i[0] pulse at cycle 5 → count_o ch0=1.
  - eot_i[0] at cycle 10 → evt_rd_eot_o[0]=1 at cycle 11 only, dir_o[0]=1, count 0.
- Queued mixed arms, channel 1:
  - Sequence rx, tx, tx, rx → count 4.
  - Four eot_i[1] pulses on consecutive cycles → output pulses rd, wr, wr, rd on the 4 following cycles; count ends at 0.
- Overflow, DEPTH=4:
  - 5 tx arms then 5 EOTs → overflow flag set.
  - Outputs: 4 wr pulses, then the 5th EOT is an underflow classified as write (dir_o=0); underflow flag set.
  - err_clr_i → both flags 0 next cycle.
- Conflict: rx_evt_i[0]=tx_evt_i[0]=1 in the same cycle → count unchanged, conflict flag=1.
- Bypass and simultaneous traffic:
  - Empty FIFO with rx arm and eot in the same cycle → rd pulse next cycle, count 0, no underflow.
  - Count=2 (rd, wr) with tx arm and eot in the same cycle → rd pulse, count stays 2, next pops are wr, wr.
- Channel independence and mid-operation reset:
  - Interleaved arms/EOTs on channels 0 and 1 → no cross-talk.
  - Assert rstn_i with count=3 → all counts/outputs 0 immediately; a post-reset EOT is classified as write with underflow.
